// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM encoding and the UART data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } uart_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping to 0.
// Zero latency; no state, so it cannot stall anything.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OWN_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [OWN_W-1:0] ptr_i,
    output logic             vld_o,
    output logic [OWN_W-1:0] idx_o
);

    int cand;

    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        cand  = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = (int'(ptr_i) + off) % N_REQ;
            if (req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = OWN_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one uart_tx: req->grant/tx_start 1 cycle, tx_finish->done 1 cycle; requests ignored while busy.
// Optional WAIT watchdog (tx_timeout) is compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ          = 4,
    parameter int  TIMEOUT_CYCLES = 4096,
    localparam int OWN_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             done,
    output logic                         busy,
    output logic [OWN_W-1:0]             owner,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    input  logic                         tx_finish,
    output logic                         tx_timeout
);

    uart_arb_state_e        state_q, state_d;
    logic [OWN_W-1:0]       ptr_q, ptr_d, ptr_adv;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d, data_sel;
    logic [N_REQ-1:0]       grant_q, grant_d, done_q, done_d;
    logic                   tx_start_q, tx_start_d;
    logic                   tx_timeout_q, tx_timeout_d;
    logic                   pick_vld;
    logic [OWN_W-1:0]       pick_idx;
    logic                   fin_evt, to_evt;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign fin_evt = (state_q == ST_WAIT) && tx_finish;
    assign ptr_adv = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q;

    // Counts completed WAIT cycles; cleared while in START so it starts at 0 on WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign to_evt = (state_q == ST_WAIT) && !tx_finish && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign to_evt     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_vld) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (fin_evt || to_evt) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_sel     = '0;
        grant_d      = '0;
        done_d       = '0;
        tx_start_d   = 1'b0;
        tx_timeout_d = 1'b0;
        owner_d      = owner_q;
        tx_data_d    = tx_data_q;
        ptr_d        = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == OWN_W'(i)) data_sel = req_data[i*UART_DATA_W +: UART_DATA_W];
        end
        if (state_q == ST_IDLE && pick_vld) begin
            for (int i = 0; i < N_REQ; i++) grant_d[i] = (pick_idx == OWN_W'(i));
            tx_start_d = 1'b1;
            owner_d    = pick_idx;
            tx_data_d  = data_sel;
        end
        if (fin_evt) begin
            for (int i = 0; i < N_REQ; i++) done_d[i] = (owner_q == OWN_W'(i));
            ptr_d = ptr_adv;
        end
        if (to_evt) begin
            tx_timeout_d = 1'b1;
            ptr_d        = ptr_adv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            owner_q      <= '0;
            tx_data_q    <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            tx_start_q   <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            tx_data_q    <= tx_data_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            tx_start_q   <= tx_start_d;
            tx_timeout_q <= tx_timeout_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign owner      = owner_q;
    assign tx_data    = tx_data_q;
    assign grant      = grant_q;
    assign done       = done_q;
    assign tx_start   = tx_start_q;
    assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of directed frames, corner sequences, random frames vs a round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, done;
    logic        busy;
    logic [1:0]  owner;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_finish;
    logic        tx_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;

    always #10 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .owner      (owner),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_finish  (tx_finish),
        .tx_timeout (tx_timeout)
    );

    typedef struct {
        logic [3:0]  r;
        logic [31:0] bytes;
        int          dly;
        int          exp_w;
        bit          keep;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int w);
        logic [3:0] v;
        v = 4'b0001;
        return v << w;
    endfunction

    // Winner = set requester with the smallest clockwise distance from the pointer.
    function automatic int rr_winner(input logic [3:0] r, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr + N) % N;
            if (r[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic do_frame(input logic [3:0] r, input logic [31:0] bytes, input int dly,
                            input int exp_w, input bit keep);
        logic [7:0] exp_b;
        exp_b    = bytes[exp_w*8 +: 8];
        req      = r;
        req_data = bytes;
        @(negedge clk);
        chk("grant", grant, onehot(exp_w));
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, exp_b);
        chk("owner", owner, exp_w);
        chk("busy_start", busy, 1);
        if (!keep) req = 4'b0000;
        @(negedge clk);
        chk("start_drop", tx_start, 0);
        chk("grant_drop", grant, 0);
        chk("busy_wait", busy, 1);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_start", tx_start, 0);
            chk("wait_grant", grant, 0);
            chk("wait_done", done, 0);
            chk("wait_data", tx_data, exp_b);
            chk("wait_timeout", tx_timeout, 0);
        end
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish = 1'b0;
        chk("done", done, onehot(exp_w));
        chk("busy_done", busy, 0);
        chk("owner_done", owner, exp_w);
        ptr_m = (exp_w + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  r;
        logic [31:0] b;
        int          w;

        tbl[0] = '{4'b1111, 32'h44332211, 3, 0, 1'b1};
        tbl[1] = '{4'b1111, 32'h44332211, 1, 1, 1'b1};
        tbl[2] = '{4'b1111, 32'h44332211, 0, 2, 1'b1};
        tbl[3] = '{4'b1111, 32'h44332211, 2, 3, 1'b1};
        tbl[4] = '{4'b1111, 32'h44332211, 4, 0, 1'b1};
        tbl[5] = '{4'b0100, 32'h00A50000, 5, 2, 1'b0};
        tbl[6] = '{4'b1001, 32'hDD0000CC, 2, 3, 1'b0};
        tbl[7] = '{4'b1001, 32'hDD0000CC, 1, 0, 1'b0};
        tbl[8] = '{4'b0001, 32'h0000005A, 3, 0, 1'b0};
        tbl[9] = '{4'b0110, 32'h00778800, 6, 1, 1'b0};

        rst       = 1'b1;
        req       = 4'b0000;
        req_data  = 32'h0;
        tx_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_timeout", tx_timeout, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            do_frame(tbl[i].r, tbl[i].bytes, tbl[i].dly, tbl[i].exp_w, tbl[i].keep);

        // Spurious tx_finish while idle.
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish = 1'b0;
        chk("idle_fin_done", done, 0);
        chk("idle_fin_busy", busy, 0);
        chk("idle_fin_start", tx_start, 0);

        // Spurious tx_finish in START, plus a request that is withdrawn before it can be granted.
        w        = rr_winner(4'b1000, ptr_m);
        req      = 4'b1000;
        req_data = 32'hE1000000;
        @(negedge clk);
        chk("start_grant", grant, onehot(w));
        req       = 4'b0000;
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish = 1'b0;
        chk("start_fin_done", done, 0);
        chk("start_fin_busy", busy, 1);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        chk("start_fin_data", tx_data, 8'hE1);
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish = 1'b0;
        chk("late_done", done, onehot(w));
        ptr_m = (w + 1) % N;
        repeat (3) begin
            @(negedge clk);
            chk("dropped_no_grant", grant, 0);
            chk("dropped_idle", busy, 0);
        end

        // Reset in the middle of WAIT abandons the frame.
        req      = 4'b0100;
        req_data = 32'h003C0000;
        @(negedge clk);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_owner", owner, 0);
        chk("midrst_data", tx_data, 0);
        chk("midrst_done", done, 0);
        tx_finish = 1'b1;
        @(negedge clk);
        tx_finish = 1'b0;
        chk("midrst_no_done", done, 0);
        ptr_m = 0;
        do_frame(4'b0010, 32'h00004B00, 2, rr_winner(4'b0010, ptr_m), 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
        w        = rr_winner(4'b0011, ptr_m);
        req      = 4'b0011;
        req_data = 32'h00009F6E;
        @(negedge clk);
        chk("to_grant", grant, onehot(w));
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("to_pulse", tx_timeout, (k == 16) ? 1 : 0);
            chk("to_busy", busy, (k == 16) ? 0 : 1);
            chk("to_no_done", done, 0);
        end
        ptr_m = (w + 1) % N;
        do_frame(4'b0011, 32'h00009F6E, 2, rr_winner(4'b0011, ptr_m), 1'b0);
`else
        do_frame(4'b1000, 32'h77000000, 40, rr_winner(4'b1000, ptr_m), 1'b0);
`endif

        for (int it = 0; it < 150; it++) begin
            r = 4'($urandom_range(0, 15));
            b = $urandom;
            if (r == 4'b0000) begin
                req      = r;
                req_data = b;
                @(negedge clk);
                chk("rnd_no_grant", grant, 0);
                chk("rnd_idle", busy, 0);
            end else begin
                do_frame(r, b, $urandom_range(0, 8), rr_winner(r, ptr_m), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
